// File: rtl/gen_share_arbiter.sv
// ---------------------------------------------------------------------------
// gen_share_arbiter
//
// Shares one resource among N_REQ replicated requesters. A requester raises
// its req bit. The arbiter answers with a registered one-hot grant. The
// grant is held until one of two things happens:
//   - the owner drops req or pulses its rel bit, or
//   - the hold limit MAX_HOLD runs out, which is a forced release.
// After every release there is a dead RECOVER cycle and then an IDLE
// evaluation, so two grants are always at least two cycles apart.
//
// The winner-selection scheme is fixed at elaboration:
//   - RR_EN = 1 : round-robin starting at a rotating pointer
//   - RR_EN = 0 : fixed priority, where the lowest index wins
//
// Parameters:
//   N_REQ    - number of requesters (2..16)
//   RR_EN    - 1 = round-robin, 0 = fixed priority
//   MAX_HOLD - maximum consecutive grant cycles (2..255)
//   IDW      - owner index width, derived from N_REQ
//
// Ports:
//   clk      - system clock, rising edge
//   rst_n    - asynchronous active-low reset
//   req      - per-requester level request
//   rel      - per-requester release; only the owner's bit is honoured
//   gnt      - registered one-hot grant
//   gnt_id   - index of the current owner, valid while busy
//   busy     - a grant is active (equals |gnt)
//   hold_cnt - cycles the current grant has been held, from 0
//   timeout  - one-cycle pulse when a grant is forcibly released
// ---------------------------------------------------------------------------
module gen_share_arbiter #(
    parameter int N_REQ    = 4,
    parameter int RR_EN    = 1,
    parameter int MAX_HOLD = 8,
    parameter int IDW      = $clog2(N_REQ)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] req,
    input  logic [N_REQ-1:0] rel,
    output logic [N_REQ-1:0] gnt,
    output logic [IDW-1:0]   gnt_id,
    output logic             busy,
    output logic [7:0]       hold_cnt,
    output logic             timeout
);

    typedef enum logic [1:0] {
        IDLE,
        GRANT,
        RECOVER
    } state_t;

    state_t           r_state;
    logic [N_REQ-1:0] r_gnt;
    logic [IDW-1:0]   r_gntId;
    logic [IDW-1:0]   r_ptr;
    logic             r_busy;
    logic [7:0]       r_holdCnt;
    logic             r_timeout;

    logic [N_REQ-1:0] w_fpSeen;
    logic [N_REQ-1:0] w_fpOneHot;
    logic [N_REQ-1:0] w_winOneHot;
    logic [IDW-1:0]   w_winIdx;
    logic [IDW-1:0]   w_ptrNext;
    logic             w_ownerRel;

    // Lowest-index priority over the raw request vector.
    // w_fpSeen[i] is set when any lower index is requesting, which blocks i.
    assign w_fpSeen[0] = 1'b0;

    for (genvar gi = 1; gi < N_REQ; gi++) begin : g_fpSeen
        assign w_fpSeen[gi] = w_fpSeen[gi-1] | req[gi-1];
    end

    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_fpTerm
        assign w_fpOneHot[gi] = req[gi] & ~w_fpSeen[gi];
    end

    if (RR_EN != 0) begin : g_rr
        logic [N_REQ-1:0] w_mkReq;
        logic [N_REQ-1:0] w_mkSeen;
        logic [N_REQ-1:0] w_mkOneHot;

        // Round-robin is done in two tiers.
        // First, requests at or above the pointer compete on their own.
        // If there are none, the search has wrapped, and the plain lowest
        // index in the full vector is the correct winner.
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_mkTerm
            assign w_mkReq[gi]    = req[gi] & (gi >= int'(r_ptr));
            assign w_mkOneHot[gi] = w_mkReq[gi] & ~w_mkSeen[gi];
        end

        assign w_mkSeen[0] = 1'b0;

        for (genvar gi = 1; gi < N_REQ; gi++) begin : g_mkSeen
            assign w_mkSeen[gi] = w_mkSeen[gi-1] | w_mkReq[gi-1];
        end

        assign w_winOneHot = (|w_mkReq) ? w_mkOneHot : w_fpOneHot;
        assign w_ptrNext   = (w_winIdx == IDW'(N_REQ - 1)) ? '0 : w_winIdx + IDW'(1);
    end else begin : g_fp
        assign w_winOneHot = w_fpOneHot;
        assign w_ptrNext   = '0;
    end

    // Convert the one-hot winner to a binary owner index.
    always_comb begin
        w_winIdx = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (w_winOneHot[i]) begin
                w_winIdx = IDW'(i);
            end
        end
    end

    // The owner gives up the grant by pulsing rel or by withdrawing req.
    assign w_ownerRel = rel[r_gntId] | ~req[r_gntId];

    // Arbitration FSM. Every output is a register updated here.
    // A voluntary release is checked before the hold limit, so a release
    // that lands on the last allowed cycle never raises timeout.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_gnt     <= '0;
            r_gntId   <= '0;
            r_ptr     <= '0;
            r_busy    <= 1'b0;
            r_holdCnt <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_timeout <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (|req) begin
                        r_gnt     <= w_winOneHot;
                        r_gntId   <= w_winIdx;
                        r_busy    <= 1'b1;
                        r_holdCnt <= '0;
                        r_ptr     <= w_ptrNext;
                        r_state   <= GRANT;
                    end
                end
                GRANT: begin
                    if (w_ownerRel) begin
                        r_gnt     <= '0;
                        r_busy    <= 1'b0;
                        r_holdCnt <= '0;
                        r_state   <= RECOVER;
                    end else if (r_holdCnt == 8'(MAX_HOLD - 1)) begin
                        r_gnt     <= '0;
                        r_busy    <= 1'b0;
                        r_holdCnt <= '0;
                        r_timeout <= 1'b1;
                        r_state   <= RECOVER;
                    end else begin
                        r_holdCnt <= r_holdCnt + 8'd1;
                    end
                end
                RECOVER: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign gnt      = r_gnt;
    assign gnt_id   = r_gntId;
    assign busy     = r_busy;
    assign hold_cnt = r_holdCnt;
    assign timeout  = r_timeout;

endmodule

// File: tb/tb_gen_share_arbiter.sv
// ---------------------------------------------------------------------------
// tb_gen_share_arbiter
//
// Drives a round-robin arbiter and a fixed-priority arbiter side by side
// from the same req/rel vectors. A shared all-ones rel pulse releases
// whichever requester currently owns each arbiter.
//
// A behavioural model tracks each arbiter in terms of its owner, how long
// that owner has held the grant, and whether a dead cycle is pending. The
// model is compared against both arbiters on every falling edge.
//
// Directed scenarios add literal expectations on top of the model:
//   - async reset while a grant is held
//   - round-robin rotation
//   - fixed-priority dominance
//   - hold-limit timeout
//   - release versus timeout precedence
//   - non-owner rel is ignored
//   - request withdrawal and pointer wrap
// ---------------------------------------------------------------------------
module tb_gen_share_arbiter;

    localparam int N    = 4;
    localparam int MAXH = 8;

    logic         clk   = 1'b0;
    logic         rst_n = 1'b0;
    logic [N-1:0] req   = '0;
    logic [N-1:0] rel   = '0;

    logic [N-1:0] gntRr;
    logic [N-1:0] gntFp;
    logic [1:0]   idRr;
    logic [1:0]   idFp;
    logic         busyRr;
    logic         busyFp;
    logic [7:0]   holdRr;
    logic [7:0]   holdFp;
    logic         toRr;
    logic         toFp;

    int nChecks = 0;
    int nFails  = 0;

    // Model state, one slot per arbiter: index 0 is RR, index 1 is FP.
    int mOwner[2]   = '{-1, -1};
    int mHeld[2]    = '{0, 0};
    bit mRecover[2] = '{1'b0, 1'b0};
    bit mTimeout[2] = '{1'b0, 1'b0};
    int mPtr[2]     = '{0, 0};

    always #5 clk = ~clk;

    gen_share_arbiter #(.N_REQ(N), .RR_EN(1), .MAX_HOLD(MAXH)) dutRr (
        .clk      (clk),
        .rst_n    (rst_n),
        .req      (req),
        .rel      (rel),
        .gnt      (gntRr),
        .gnt_id   (idRr),
        .busy     (busyRr),
        .hold_cnt (holdRr),
        .timeout  (toRr)
    );

    gen_share_arbiter #(.N_REQ(N), .RR_EN(0), .MAX_HOLD(MAXH)) dutFp (
        .clk      (clk),
        .rst_n    (rst_n),
        .req      (req),
        .rel      (rel),
        .gnt      (gntFp),
        .gnt_id   (idFp),
        .busy     (busyFp),
        .hold_cnt (holdFp),
        .timeout  (toFp)
    );

    task automatic checkOutput(input string name, input int actual, input int expected);
        nChecks++;
        if (actual != expected) begin
            nFails++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic [N-1:0] r, input logic [N-1:0] l);
        req = r;
        rel = l;
    endtask

    // Picks a winner from the request vector.
    // Round-robin searches upward from the pointer and wraps; fixed
    // priority searches upward from 0.
    function automatic int pickWinner(input int m, input logic [N-1:0] r);
        int start;
        start = (m == 0) ? mPtr[m] : 0;
        for (int k = 0; k < N; k++) begin
            if (r[(start + k) % N]) begin
                return (start + k) % N;
            end
        end
        return -1;
    endfunction

    task automatic modelStep(input int m);
        if (!rst_n) begin
            mOwner[m]   = -1;
            mHeld[m]    = 0;
            mRecover[m] = 1'b0;
            mTimeout[m] = 1'b0;
            mPtr[m]     = 0;
        end else begin
            mTimeout[m] = 1'b0;
            if (mOwner[m] >= 0) begin
                if (rel[mOwner[m]] || !req[mOwner[m]]) begin
                    mOwner[m]   = -1;
                    mHeld[m]    = 0;
                    mRecover[m] = 1'b1;
                end else if (mHeld[m] == MAXH - 1) begin
                    mOwner[m]   = -1;
                    mHeld[m]    = 0;
                    mRecover[m] = 1'b1;
                    mTimeout[m] = 1'b1;
                end else begin
                    mHeld[m] = mHeld[m] + 1;
                end
            end else if (mRecover[m]) begin
                mRecover[m] = 1'b0;
            end else if (req != '0) begin
                mOwner[m] = pickWinner(m, req);
                mHeld[m]  = 0;
                mPtr[m]   = (mOwner[m] + 1) % N;
            end
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        modelStep(0);
        modelStep(1);
    end

    task automatic compareDut(input int m, input logic [N-1:0] g, input logic [1:0] id,
                              input logic b, input logic [7:0] h, input logic t);
        string tag;
        int    expG;
        tag  = (m == 0) ? "rr" : "fp";
        expG = (mOwner[m] >= 0) ? (1 << mOwner[m]) : 0;
        checkOutput({tag, ".gnt"}, int'(g), expG);
        checkOutput({tag, ".busy"}, int'(b), int'(mOwner[m] >= 0));
        checkOutput({tag, ".hold_cnt"}, int'(h), mHeld[m]);
        checkOutput({tag, ".timeout"}, int'(t), int'(mTimeout[m]));
        if (mOwner[m] >= 0) begin
            checkOutput({tag, ".gnt_id"}, int'(id), mOwner[m]);
        end
    endtask

    always @(negedge clk) begin
        compareDut(0, gntRr, idRr, busyRr, holdRr, toRr);
        compareDut(1, gntFp, idFp, busyFp, holdFp, toFp);
    end

    // Waits, with a bounded number of cycles, until the chosen arbiter is
    // busy. waits counts the falling edges observed, including the one on
    // which busy was finally seen.
    task automatic waitBusy(input int m, output int waits);
        bit seen;
        seen  = 1'b0;
        waits = 0;
        while (!seen && waits < 12) begin
            @(negedge clk);
            waits++;
            seen = (m == 0) ? busyRr : busyFp;
        end
        checkOutput((m == 0) ? "rr.grantArrives" : "fp.grantArrives", int'(seen), 1);
    endtask

    task automatic applyReset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int waits;
        int expOrder[5];
        expOrder = '{0, 1, 2, 3, 0};

        // Reset, then a grant that is cut short by a mid-grant reset.
        repeat (3) @(negedge clk);
        checkOutput("reset.gnt", int'(gntRr), 0);
        checkOutput("reset.busy", int'(busyRr), 0);
        checkOutput("reset.timeout", int'(toRr), 0);
        rst_n = 1'b1;
        applyStimulus(4'b0001, 4'b0000);
        @(negedge clk);
        checkOutput("firstGrant.gnt", int'(gntRr), 1);
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("asyncReset.gnt", int'(gntRr), 0);
        checkOutput("asyncReset.busy", int'(busyRr), 0);
        checkOutput("asyncReset.timeout", int'(toRr), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("postReset.gnt", int'(gntRr), 1);
        checkOutput("postReset.hold", int'(holdRr), 0);
        applyStimulus(4'b0000, 4'b0000);
        repeat (3) @(negedge clk);

        // Round-robin rotation. Each owner is released after two cycles.
        applyReset();
        applyStimulus(4'b1111, 4'b0000);
        for (int k = 0; k < 5; k++) begin
            waitBusy(0, waits);
            checkOutput("rr.gapCycles", waits, (k == 0) ? 1 : 2);
            checkOutput("rr.order", int'(idRr), expOrder[k]);
            checkOutput("rr.orderOneHot", int'(gntRr), 1 << expOrder[k]);
            @(negedge clk);
            applyStimulus(4'b1111, 4'b1111);
            @(negedge clk);
            checkOutput("rr.released", int'(busyRr), 0);
            applyStimulus(4'b1111, 4'b0000);
        end

        // Fixed priority. Index 1 wins every time over index 3.
        applyStimulus(4'b1010, 4'b0000);
        for (int k = 0; k < 3; k++) begin
            waitBusy(1, waits);
            checkOutput("fp.winner", int'(idFp), 1);
            @(negedge clk);
            applyStimulus(4'b1010, 4'b1111);
            @(negedge clk);
            checkOutput("fp.released", int'(busyFp), 0);
            applyStimulus(4'b1010, 4'b0000);
        end
        applyStimulus(4'b0000, 4'b0000);
        repeat (3) @(negedge clk);

        // Hold timeout. Requester 2 never releases.
        applyStimulus(4'b0100, 4'b0000);
        waitBusy(0, waits);
        for (int c = 0; c < MAXH; c++) begin
            checkOutput("timeout.busyWindow", int'(busyRr), 1);
            checkOutput("timeout.holdCount", int'(holdRr), c);
            @(negedge clk);
        end
        checkOutput("timeout.dropBusy", int'(busyRr), 0);
        checkOutput("timeout.pulse", int'(toRr), 1);
        @(negedge clk);
        checkOutput("timeout.pulseEnds", int'(toRr), 0);
        @(negedge clk);
        checkOutput("timeout.regrant", int'(idRr), 2);
        checkOutput("timeout.regrantBusy", int'(busyRr), 1);

        // Non-owner rel is ignored. Owner rel on the last cycle is a normal
        // release with no timeout.
        repeat (2) @(negedge clk);
        applyStimulus(4'b0100, 4'b0001);
        @(negedge clk);
        checkOutput("nonOwnerRel.busy", int'(busyRr), 1);
        checkOutput("nonOwnerRel.hold", int'(holdRr), 3);
        applyStimulus(4'b0100, 4'b0000);
        repeat (4) @(negedge clk);
        checkOutput("lastCycle.hold", int'(holdRr), 7);
        applyStimulus(4'b0100, 4'b0100);
        @(negedge clk);
        checkOutput("relVsTimeout.busy", int'(busyRr), 0);
        checkOutput("relVsTimeout.timeout", int'(toRr), 0);
        applyStimulus(4'b0000, 4'b0000);
        repeat (3) @(negedge clk);

        // Withdrawal by owner 3, then the pointer wraps to 0.
        applyStimulus(4'b1001, 4'b0000);
        waitBusy(0, waits);
        checkOutput("wrap.owner3", int'(idRr), 3);
        @(negedge clk);
        applyStimulus(4'b0001, 4'b0000);
        @(negedge clk);
        checkOutput("withdraw.busy", int'(busyRr), 0);
        applyStimulus(4'b1001, 4'b0000);
        waitBusy(0, waits);
        checkOutput("wrap.owner0", int'(idRr), 0);
        applyStimulus(4'b0000, 4'b0000);
        repeat (12) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
